// File: rtl/uart_baud_gen_if.sv
// Control and strobe bundle between the UART register wrapper and the baud tick generator.
// The wrapper (master) supplies divisor/fraction/enable; the generator (slave) returns the strobes.
interface uart_baud_gen_if;
  logic        ENABLE;
  logic [12:0] BAUD_VAL;
  logic [2:0]  BAUD_VAL_FRACTION;
  logic        BAUD_CLOCK;
  logic        XMIT_PULSE;

  modport master (
    output ENABLE,
    output BAUD_VAL,
    output BAUD_VAL_FRACTION,
    input  BAUD_CLOCK,
    input  XMIT_PULSE
  );

  modport slave (
    input  ENABLE,
    input  BAUD_VAL,
    input  BAUD_VAL_FRACTION,
    output BAUD_CLOCK,
    output XMIT_PULSE
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud tick generator: 16x oversampling strobe plus a once-per-bit transmit pulse.
// Average tick period is BAUD_VAL+1+f/8 clocks, achieved by stretching f out of every 8 periods.
module uart_baud_gen #(
  parameter bit BAUD_VAL_FRCTN_EN = 1'b0
) (
  input logic           CLK,
  input logic           RESET,
  uart_baud_gen_if.slave bus
);

  logic [12:0] div_cnt_reg,  div_cnt_next;
  logic [2:0]  frac_cnt_reg, frac_cnt_next;
  logic [3:0]  xmit_cnt_reg, xmit_cnt_next;
  logic        ext_reg,      ext_next;
  logic        baud_clock_reg;
  logic        xmit_pulse_reg;
  logic [2:0]  frac_sel;
  logic        tick_c;
  logic        xmit_c;

  generate
    if (BAUD_VAL_FRCTN_EN) begin : g_frac
      assign frac_sel = bus.BAUD_VAL_FRACTION;
    end else begin : g_nofrac
      assign frac_sel = 3'd0;
    end
  endgenerate

  // Divisor and fraction are only consulted at the terminal count, so a
  // mid-period change never shortens the period already in progress.
  always_comb begin
    div_cnt_next  = div_cnt_reg;
    frac_cnt_next = frac_cnt_reg;
    xmit_cnt_next = xmit_cnt_reg;
    ext_next      = ext_reg;
    tick_c        = 1'b0;
    if (bus.ENABLE) begin
      if (div_cnt_reg != 13'd0) begin
        div_cnt_next = div_cnt_reg - 13'd1;
      end else if ((frac_cnt_reg < frac_sel) && !ext_reg) begin
        ext_next = 1'b1;
      end else begin
        tick_c        = 1'b1;
        div_cnt_next  = bus.BAUD_VAL;
        ext_next      = 1'b0;
        frac_cnt_next = frac_cnt_reg + 3'd1;
        xmit_cnt_next = xmit_cnt_reg + 4'd1;
      end
    end
  end

  assign xmit_c = tick_c && (xmit_cnt_reg == 4'hF);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt_reg    <= 13'd0;
      frac_cnt_reg   <= 3'd0;
      xmit_cnt_reg   <= 4'd0;
      ext_reg        <= 1'b0;
      baud_clock_reg <= 1'b0;
      xmit_pulse_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      frac_cnt_reg   <= frac_cnt_next;
      xmit_cnt_reg   <= xmit_cnt_next;
      ext_reg        <= ext_next;
      baud_clock_reg <= tick_c;
      xmit_pulse_reg <= xmit_c;
    end
  end

  assign bus.BAUD_CLOCK = baud_clock_reg;
  assign bus.XMIT_PULSE = xmit_pulse_reg;

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Fractional baud-rate tick generator feeding the UART core's transmit and receive engines.
- Consumes the 13-bit baud divisor and 3-bit fraction presented by the APB register wrapper.
- Produces a 16x-oversampling BAUD_CLOCK strobe for receive sampling and a once-per-bit XMIT_PULSE strobe for the transmitter.
- Fraction support stretches selected divider periods by one clock, so the average tick period is BAUD_VAL+1+FRACTION/8 clocks.

Parameters:
- BAUD_VAL_FRCTN_EN, 0: 1 enables fractional stretching; 0 ignores BAUD_VAL_FRACTION (treated as 0).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  count enable; low freezes all counters.
- BAUD_VAL  in  13  integer divisor; tick period = BAUD_VAL+1 clocks.
- BAUD_VAL_FRACTION  in  3  fractional eighths added to the period.
- BAUD_CLOCK  out  1  registered single-cycle 16x tick.
- XMIT_PULSE  out  1  registered single-cycle pulse on every 16th tick.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports CLK, RESET).
- Reset state: div_cnt=0, frac_cnt=0, xmit_cnt=0, ext=0. Outputs BAUD_CLOCK=0 and XMIT_PULSE=0.
- RESET has priority over ENABLE. Asserting RESET mid-period clears all state at the next edge; no partial tick is emitted.
- f = BAUD_VAL_FRACTION when BAUD_VAL_FRCTN_EN=1, else 0.
- Terminal condition T = ENABLE && div_cnt==0.
- Per clock, when ENABLE=1:
  - div_cnt != 0: div_cnt decrements; ext holds.
  - T, with frac_cnt < f and ext=0: stretch cycle. Set ext=1, hold div_cnt at 0, no tick.
  - T otherwise: tick cycle. Set tick_c=1, load div_cnt with BAUD_VAL, clear ext, frac_cnt<=frac_cnt+1 (mod 8), xmit_cnt<=xmit_cnt+1 (mod 16).
- Outputs are registered:
  - BAUD_CLOCK <= tick_c.
  - XMIT_PULSE <= tick_c && xmit_cnt==15 (pre-increment value).
  - Both are high in the cycle after the tick cycle; latency is 1 clock.
- Resulting periods: in each group of 8 ticks (frac_cnt 0..7), the first f ticks have period BAUD_VAL+2 and the remaining 8-f have period BAUD_VAL+1.
- BAUD_VAL and f are sampled only at the reload or stretch decision. A mid-period change takes effect on the next period and never truncates the current one.
- BAUD_VAL=0 is legal: period 1 (tick every enabled cycle), or 2 when stretched.
- ENABLE=0: all counters and ext hold; tick_c=0, so both outputs are 0 in the following cycle. Counting resumes from the held state.
- Arithmetic: div_cnt is 13 bits, never wraps below 0. frac_cnt and xmit_cnt are free-running modulo 8 and 16, advanced only on ticks.
- No combinational path from inputs to outputs.

Test Plan (cycle 0 = first edge with RESET=0):
- BAUD_VAL=3, f=0, ENABLE=1 -> BAUD_CLOCK high in cycles 1,5,9,... (period 4); XMIT_PULSE high in cycle 61, then every 64 cycles; BAUD_CLOCK also high in those cycles.
- BAUD_VAL=3, BAUD_VAL_FRACTION=3, BAUD_VAL_FRCTN_EN=1 -> tick periods 5,5,5,4,4,4,4,4 repeating; 35 clocks per 8 ticks. Same stimulus with BAUD_VAL_FRCTN_EN=0 -> constant period 4.
- BAUD_VAL=0, fraction 4, enabled -> periods 2,2,2,2,1,1,1,1. Fraction 0 -> BAUD_CLOCK high every cycle from cycle 1; XMIT_PULSE every 16 cycles.
- BAUD_VAL=3, f=0: drop ENABLE for 10 cycles starting at cycle 3 -> outputs stay 0 during the gap. The next tick arrives exactly 1 enabled cycle after resume, i.e. the tick expected at cycle 5 shifts to cycle 15.
- BAUD_VAL changed 3->7 at cycle 2 -> next tick still at cycle 5 (old period honoured), then period 8 (cycles 13,21,...).
- RESET pulsed at cycle 20 with xmit_cnt=5 -> outputs 0 during reset; after release the tick pattern restarts as in scenario 1, and the first XMIT_PULSE comes 61 cycles after release.
